elastic_fifo: RTL and testbench

Multi-entry elastic buffer and the parametrised successor to the single-entry elastic stage. It uses a valid/ready handshake on both sides and holds up to depth_p beats in a circular buffer. Both ready_o and valid_o are driven from registered state only, so there is no combinational path from ready_i to ready_o. It sits between pipeline stages that need decoupling, or burst absorption longer than one beat, and it sustains one beat per cycle in steady state.

---
 rtl/elastic_pkg.sv | 14 +
 rtl/elastic_wrap_ctr.sv | 34 +++
 rtl/elastic_fifo.sv | 91 +++++++++
 tb/tb_elastic_fifo.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/elastic_pkg.sv
// Shared width helpers for the elastic FIFO and its pointer counters.
package elastic_pkg;

   // Pointer width: enough bits to index depth entries, never narrower than 1.
   function automatic int ptr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/elastic_wrap_ctr.sv
// Modulo-(max_p+1) counter used for the FIFO read and write pointers.
module elastic_wrap_ctr
   import elastic_pkg::*;
#(
   parameter int max_p   = 3,
   parameter int width_p = ptr_width(max_p + 1)
) (
   input  logic               clk_i,
   input  logic               clr_i,
   input  logic               inc_i,
   output logic [width_p-1:0] value_o
);

   localparam logic [width_p-1:0] MAX_C = width_p'(max_p);

   logic [width_p-1:0] value_q, value_d;

   // Next value: clear wins, otherwise step and wrap max_p back to zero.
   always_comb begin
      value_d = value_q;
      if (clr_i)
         value_d = '0;
      else if (inc_i)
         value_d = (value_q == MAX_C) ? '0 : value_q + 1'b1;
   end

   // Pointer register; clr_i carries the synchronous reset from the parent.
   always_ff @(posedge clk_i) begin
      value_q <= value_d;
   end

   assign value_o = value_q;

endmodule

// File: rtl/elastic_fifo.sv
// Multi-entry valid/ready elastic buffer. ready_o/valid_o/count_o come only
// from the registered occupancy count, so nothing flows combinationally from
// the downstream ready to the upstream ready.
module elastic_fifo
   import elastic_pkg::*;
#(
   parameter int width_p          = 8,
   parameter int depth_p          = 4,
   parameter int datapath_reset_p = 0,
   parameter int datapath_gate_p  = 0
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          flush_i,
   input  logic [width_p-1:0]            data_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   output logic                          valid_o,
   output logic [width_p-1:0]            data_o,
   input  logic                          ready_i,
   output logic [cnt_width(depth_p)-1:0] count_o
);

   localparam int PW = ptr_width(depth_p);
   localparam int CW = cnt_width(depth_p);
   localparam logic [CW-1:0] DEPTH_C = CW'(depth_p);

   logic [CW-1:0]      count_q, count_d;
   logic [PW-1:0]      rd_ptr, wr_ptr;
   logic [width_p-1:0] mem_q [depth_p];
   logic               clr, push, pop, we;

   assign ready_o = (count_q != DEPTH_C);
   assign valid_o = (count_q != '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr];

   // Reset and flush both discard any handshake in the same cycle.
   assign clr  = reset_i | flush_i;
   assign push = valid_i & ready_o & ~clr;
   assign pop  = valid_o & ready_i & ~clr;

   // Ungated mode writes the free slot every cycle there is room; the slot is
   // not part of the held data until a push advances wr_ptr past it.
   assign we = ((datapath_gate_p != 0) ? push : ready_o) & ~clr;

   elastic_wrap_ctr #(.max_p(depth_p - 1), .width_p(PW)) u_rd_ctr (
      .clk_i   (clk_i),
      .clr_i   (clr),
      .inc_i   (pop),
      .value_o (rd_ptr)
   );

   elastic_wrap_ctr #(.max_p(depth_p - 1), .width_p(PW)) u_wr_ctr (
      .clk_i   (clk_i),
      .clr_i   (clr),
      .inc_i   (push),
      .value_o (wr_ptr)
   );

   // Occupancy: flush empties; simultaneous push and pop leave it unchanged.
   always_comb begin
      count_d = count_q;
      if (flush_i)
         count_d = '0;
      else begin
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Occupancy register.
   always_ff @(posedge clk_i) begin
      if (reset_i) count_q <= '0;
      else         count_q <= count_d;
   end

   // Storage array; optionally zeroed on reset, never touched by flush.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         if (datapath_reset_p != 0)
            for (int i = 0; i < depth_p; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[wr_ptr] <= data_i;
      end
   end

endmodule

// File: tb/tb_elastic_fifo.sv
// Self-checking bench: two FIFO instances (depth 4 with datapath reset and
// ungated writes, depth 3 with gated writes) share one stimulus stream and are
// each compared against a queue model after every clock.
module tb_elastic_fifo;

   logic       clk = 1'b0;
   logic       rst, flush, vin, rdy;
   logic [7:0] din;

   logic       rdy4, vld4, rdy3, vld3;
   logic [7:0] dout4, dout3;
   logic [2:0] cnt4;
   logic [1:0] cnt3;

   logic [7:0] q4[$];
   logic [7:0] q3[$];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   elastic_fifo #(.width_p(8), .depth_p(4), .datapath_reset_p(1), .datapath_gate_p(0)) u4 (
      .clk_i(clk), .reset_i(rst), .flush_i(flush), .data_i(din), .valid_i(vin),
      .ready_o(rdy4), .valid_o(vld4), .data_o(dout4), .ready_i(rdy), .count_o(cnt4)
   );

   elastic_fifo #(.width_p(8), .depth_p(3), .datapath_reset_p(0), .datapath_gate_p(1)) u3 (
      .clk_i(clk), .reset_i(rst), .flush_i(flush), .data_i(din), .valid_i(vin),
      .ready_o(rdy3), .valid_o(vld3), .data_o(dout3), .ready_i(rdy), .count_o(cnt3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare both instances with their models and the occupancy invariants.
   task automatic check_models();
      chk("u4.count", 32'(cnt4), q4.size());
      chk("u4.valid", 32'(vld4), 32'(q4.size() != 0));
      chk("u4.ready", 32'(rdy4), 32'(q4.size() != 4));
      if (q4.size() != 0) chk("u4.data", 32'(dout4), 32'(q4[0]));
      chk("u3.count", 32'(cnt3), q3.size());
      chk("u3.valid", 32'(vld3), 32'(q3.size() != 0));
      chk("u3.ready", 32'(rdy3), 32'(q3.size() != 3));
      if (q3.size() != 0) chk("u3.data", 32'(dout3), 32'(q3[0]));
      chk("u4.inv_cnt", 32'(cnt4 <= 3'd4), 32'd1);
      chk("u4.inv_vld", 32'(vld4 == (cnt4 != 3'd0)), 32'd1);
      chk("u4.inv_rdy", 32'(rdy4 == (cnt4 != 3'd4)), 32'd1);
      chk("u3.inv_vld", 32'(vld3 == (cnt3 != 2'd0)), 32'd1);
      chk("u3.inv_rdy", 32'(rdy3 == (cnt3 != 2'd3)), 32'd1);
   endtask

   // One clock: decide the model handshakes from pre-edge occupancy, advance
   // the models at the edge, then check 1 time unit later.
   task automatic step();
      bit p4, o4, p3, o3, kill;
      kill = rst || flush;
      p4 = vin && q4.size() < 4 && !kill;
      o4 = rdy && q4.size() > 0 && !kill;
      p3 = vin && q3.size() < 3 && !kill;
      o3 = rdy && q3.size() > 0 && !kill;
      @(posedge clk);
      if (kill) begin
         q4.delete();
         q3.delete();
      end else begin
         if (o4) void'(q4.pop_front());
         if (p4) q4.push_back(din);
         if (o3) void'(q3.pop_front());
         if (p3) q3.push_back(din);
      end
      #1;
      check_models();
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic r);
      vin = v; din = d; rdy = r;
      step();
   endtask

   initial begin
      logic [7:0] fill [4];
      fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
      rst = 1'b1; flush = 1'b0; vin = 1'b0; rdy = 1'b0; din = 8'h00;
      step(); step();
      rst = 1'b0;
      chk("rst.count", 32'(cnt4), 32'd0);
      chk("rst.valid", 32'(vld4), 32'd0);
      chk("rst.ready", 32'(rdy4), 32'd1);
      chk("rst.data0", 32'(dout4), 32'h00);

      // Fill with the sink stalled; the 5th beat must be refused.
      for (int i = 0; i < 4; i++) drive(1'b1, fill[i], 1'b0);
      chk("fill.ready", 32'(rdy4), 32'd0);
      chk("fill.count", 32'(cnt4), 32'd4);
      drive(1'b1, 8'h55, 1'b0);
      chk("fill.5th_count", 32'(cnt4), 32'd4);
      chk("fill.head", 32'(dout4), 32'h11);

      // Full with push and pop offered together: only the pop happens.
      drive(1'b1, 8'h66, 1'b1);
      chk("fullpop.count", 32'(cnt4), 32'd3);
      chk("fullpop.ready", 32'(rdy4), 32'd1);
      chk("fullpop.head", 32'(dout4), 32'h22);
      drive(1'b0, 8'h00, 1'b1);
      chk("drain.head", 32'(dout4), 32'h33);
      drive(1'b0, 8'h00, 1'b1);
      chk("drain.head", 32'(dout4), 32'h44);
      chk("drain.count", 32'(cnt4), 32'd1);
      drive(1'b0, 8'h00, 1'b1);
      chk("drain.valid", 32'(vld4), 32'd0);
      drive(1'b0, 8'h00, 1'b1);

      // Streaming through depth 3: one beat per cycle, pointers wrap.
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 8'(i), 1'b1);
         chk("stream.data", 32'(dout3), i);
         chk("stream.count", 32'(cnt3), 32'd1);
      end
      drive(1'b0, 8'h00, 1'b1);
      chk("stream.empty", 32'(vld3), 32'd0);

      // Backpressure hold.
      drive(1'b1, 8'hA5, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 8'h00, 1'b0);
         chk("hold.data", 32'(dout4), 32'hA5);
         chk("hold.valid", 32'(vld4), 32'd1);
      end
      drive(1'b0, 8'h00, 1'b1);

      // Flush with a push offered: the push is discarded.
      drive(1'b1, 8'h01, 1'b0);
      drive(1'b1, 8'h02, 1'b0);
      chk("flush.pre_count", 32'(cnt4), 32'd2);
      flush = 1'b1;
      drive(1'b1, 8'h77, 1'b1);
      flush = 1'b0;
      chk("flush.count", 32'(cnt4), 32'd0);
      chk("flush.valid", 32'(vld4), 32'd0);
      chk("flush.ready", 32'(rdy4), 32'd1);
      chk("flush.no77_u4", 32'(dout4 != 8'h77), 32'd1);
      chk("flush.no77_u3", 32'(dout3 != 8'h77), 32'd1);
      drive(1'b1, 8'h88, 1'b0);
      chk("flush.next_head", 32'(dout4), 32'h88);
      drive(1'b0, 8'h00, 1'b1);

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         flush = ($urandom_range(0, 31) == 0);
         drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
      end
      flush = 1'b0;

      // Reset mid-stream.
      drive(1'b0, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 1'b1);
      drive(1'b1, 8'hC1, 1'b0);
      drive(1'b1, 8'hC2, 1'b0);
      drive(1'b1, 8'hC3, 1'b0);
      chk("midrst.pre_count", 32'(cnt4), 32'd3);
      rst = 1'b1;
      drive(1'b1, 8'hC4, 1'b1);
      rst = 1'b0;
      chk("midrst.count", 32'(cnt4), 32'd0);
      chk("midrst.valid", 32'(vld4), 32'd0);
      chk("midrst.ready", 32'(rdy4), 32'd1);
      chk("midrst.data", 32'(dout4), 32'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
